irrigation_sequencer: RTL and testbench
=======================================

# irrigation_sequencer

Downstream stage of the irrigation permit logic. It takes the single-bit `irrigation` permit (dry earth, sensors consistent, water above critical) and turns it into timed watering runs on exactly one actuator, dripper or sprinkler. Each run follows a fixed sequence: debounce the permit, run the valve for a fixed time, then force a rest period. Losing the permit aborts the run immediately.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive permit-high samples required before a run starts. Minimum 1.
- `RUN_CYCLES`, default 20: valve-on duration of a complete run, in clock cycles. Minimum 1.
- `REST_CYCLES`, default 10: forced valve-off period after every run, whether complete or aborted. Minimum 1.
- `CNT_W`, default 8: width of the internal timer. Must hold max(parameter) − 1.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `irrigation`  in  1: permit from upstream. Synchronous to `clock`.
- `mode`  in  1: actuator select. 0 = dripper, 1 = sprinkler.
- `dripper_valve`  out  1: dripper actuator enable.
- `sprinkler_valve`  out  1: sprinkler actuator enable.
- `busy`  out  1: high whenever the state is not IDLE.
- `run_count`  out  8: number of completed runs, saturating at 255.
- `abort_count`  out  8: number of aborted runs, saturating at 255. Only meaningful when the Configuration macro is defined.

## Operation
- The FSM has four states: IDLE, ARM, RUN, REST. It uses one shared timer `t`.
- IDLE:
  - `irrigation`=1 → go to ARM, `t`=1.
  - If `DEBOUNCE_CYCLES`=1, go directly to RUN instead.
- ARM:
  - `irrigation`=0 → go to IDLE.
  - `irrigation`=1 and `t`==`DEBOUNCE_CYCLES`−1 → go to RUN, `t`=0, and latch `mode` into `sel`.
  - Otherwise increment `t`.
- RUN:
  - `irrigation`=0 → abort: go to REST, `t`=0, increment `abort_count` (saturating).
  - Else if `t`==`RUN_CYCLES`−1 → go to REST, `t`=0, increment `run_count` (saturating).
  - Otherwise increment `t`.
- REST:
  - Ignores `irrigation` and `mode`.
  - `t`==`REST_CYCLES`−1 → go to IDLE. Otherwise increment `t`.
- Outputs are decoded from registered state only:
  - `dripper_valve` = (RUN && !`sel`).
  - `sprinkler_valve` = (RUN && `sel`).
  - The two valves are never high together.
- `mode` changes during ARM take effect at RUN entry. Changes during RUN or REST have no effect.
- Simultaneous events: permit low on the final RUN cycle counts as an abort. Abort takes priority over completion.
- Saturation: both counters hold at 255 and never wrap.

## Timing
- Reset (async assert, mid-operation included):
  - State = IDLE, `t`=0, `sel`=0.
  - Both valves = 0, `busy`=0, `run_count`=0, `abort_count`=0.
  - All of the above take effect immediately, without waiting for a clock edge.
- Start latency: the permit first sampled high at edge N, and held high, asserts the valve after edge N+`DEBOUNCE_CYCLES`−1.
- Run length: a complete run keeps the valve high for exactly `RUN_CYCLES` cycles.
- Abort latency: the permit sampled low at edge M drops the valve after edge M, i.e. one cycle.
- Rest: exactly `REST_CYCLES` cycles. After that, IDLE for at least one cycle before ARM can begin.
- A continuously high permit gives a period of 1 + (`DEBOUNCE_CYCLES`−1) + `RUN_CYCLES` + `REST_CYCLES` cycles per run.
- Counters update on the same edge as the RUN→REST transition.

## Configuration
- `IRRIGATION_SEQ_ABORT_COUNT_EN`
  - Defined: `abort_count` is a saturating 8-bit register, as described in Operation.
  - Undefined: `abort_count` is tied to 0 and the register is not built.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-RUN with `mode`=1: assert `reset_n`=0 → `sprinkler_valve` goes 0 without a clock edge, and all counters read 0.
- Permit held high, defaults, `mode`=0:
  - `dripper_valve` rises 4 edges after permit first sampled, stays high 20 cycles, then low 10 cycles.
  - `run_count`=1, repeat period 34 cycles.
- Permit glitch during ARM (high 2 cycles, low 1, high): no valve activity until 4 consecutive high samples are seen. `run_count` is unchanged by the glitch.
- Permit drops on RUN cycle 20 (last cycle):
  - Valve low next cycle, `run_count` unchanged.
  - `abort_count`=1 with the macro defined, 0 without it.
- Toggle `mode` during RUN and REST: the active valve never switches mid-run, and the two valves are never both high.
- 256 complete runs: `run_count` saturates at 255 and stays there.

Source files
------------

// File: rtl/irrigation_sequencer.sv
// Turns the irrigation permit into debounced, timed valve runs followed by a forced rest.
// Optional abort counter is built only when IRRIGATION_SEQ_ABORT_COUNT_EN is defined.
module irrigation_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RUN_CYCLES      = 20,
    parameter int unsigned REST_CYCLES     = 10,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       irrigation,
    input  logic       mode,
    output logic       dripper_valve,
    output logic       sprinkler_valve,
    output logic       busy,
    output logic [7:0] run_count,
    output logic [7:0] abort_count
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StRest} state_e;

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RunLast  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RestLast = CNT_W'(REST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             sel_q, sel_d;
    logic [7:0]       run_count_q, run_count_d;
    logic             run_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            t_q         <= '0;
            sel_q       <= 1'b0;
            run_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            sel_q       <= sel_d;
            run_count_q <= run_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (irrigation) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StRun;
                        t_d     = '0;
                        sel_d   = mode;
                    end else begin
                        state_d = StArm;
                        t_d     = TOne;
                    end
                end
            end
            StArm: begin
                if (!irrigation) begin
                    state_d = StIdle;
                    t_d     = '0;
                end else if (t_q == DebLast) begin
                    state_d = StRun;
                    t_d     = '0;
                    sel_d   = mode;
                end else begin
                    t_d = t_q + TOne;
                end
            end
            StRun: begin
                // Permit loss wins over completion on the final cycle.
                if (!irrigation || (t_q == RunLast)) begin
                    state_d = StRest;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TOne;
                end
            end
            StRest: begin
                if (t_q == RestLast) begin
                    state_d = StIdle;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TOne;
                end
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
            end
        endcase
    end

    assign run_done = (state_q == StRun) && irrigation && (t_q == RunLast);

    always_comb begin
        run_count_d = run_count_q;
        if (run_done && (run_count_q != 8'hFF)) begin
            run_count_d = run_count_q + 8'd1;
        end
    end

`ifdef IRRIGATION_SEQ_ABORT_COUNT_EN
    logic [7:0] abort_count_q, abort_count_d;
    logic       run_abort;

    assign run_abort = (state_q == StRun) && !irrigation;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            abort_count_q <= 8'd0;
        end else begin
            abort_count_q <= abort_count_d;
        end
    end

    always_comb begin
        abort_count_d = abort_count_q;
        if (run_abort && (abort_count_q != 8'hFF)) begin
            abort_count_d = abort_count_q + 8'd1;
        end
    end

    assign abort_count = abort_count_q;
`else
    assign abort_count = 8'd0;
`endif

    // Outputs decode registered state only, so async reset clears them at once.
    assign dripper_valve   = (state_q == StRun) && !sel_q;
    assign sprinkler_valve = (state_q == StRun) && sel_q;
    assign busy            = (state_q != StIdle);
    assign run_count       = run_count_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with default parameters.
module tb_irrigation_sequencer;

    logic       clock;
    logic       reset_n;
    logic       irrigation;
    logic       mode;
    logic       dripper_valve;
    logic       sprinkler_valve;
    logic       busy;
    logic [7:0] run_count;
    logic [7:0] abort_count;

    int errors = 0;
    int checks = 0;

`ifdef IRRIGATION_SEQ_ABORT_COUNT_EN
    localparam int unsigned AbortInc = 1;
`else
    localparam int unsigned AbortInc = 0;
`endif

    irrigation_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .irrigation     (irrigation),
        .mode           (mode),
        .dripper_valve  (dripper_valve),
        .sprinkler_valve(sprinkler_valve),
        .busy           (busy),
        .run_count      (run_count),
        .abort_count    (abort_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b1;
        irrigation = 1'b0;
        mode       = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_drip", dripper_valve, 0);
        chk("rst_sprk", sprinkler_valve, 0);
        chk("rst_busy", busy, 0);
        chk("rst_runc", run_count, 0);
        chk("rst_abtc", abort_count, 0);
        repeat (2) step();
        chk("rst_busy2", busy, 0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Held permit, dripper: debounce, 20-cycle run, rest, re-arm.
        irrigation = 1'b1;
        mode       = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("arm_drip", dripper_valve, 0);
            chk("arm_busy", busy, 1);
        end
        step();
        chk("start_drip", dripper_valve, 1);
        chk("start_sprk", sprinkler_valve, 0);
        for (int i = 1; i <= 34; i++) begin
            step();
            chk("cyc_drip", dripper_valve, ((i < 20) || (i == 34)) ? 1 : 0);
            chk("cyc_sprk", sprinkler_valve, 0);
            chk("cyc_busy", busy, (i != 30) ? 1 : 0);
            if (i == 20) chk("cyc_runc", run_count, 1);
        end

        // Permit drops on the last RUN cycle: abort, not completion.
        for (int i = 1; i <= 19; i++) begin
            step();
            chk("run2_drip", dripper_valve, 1);
        end
        irrigation = 1'b0;
        step();
        chk("abt_drip", dripper_valve, 0);
        chk("abt_runc", run_count, 1);
        chk("abt_abtc", abort_count, AbortInc);
        chk("abt_busy", busy, 1);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("abt_rest", busy, (i != 10) ? 1 : 0);
        end

        // Glitch during ARM restarts the debounce.
        mode       = 1'b1;
        irrigation = 1'b1;
        step();
        chk("gl_sprk1", sprinkler_valve, 0);
        chk("gl_busy1", busy, 1);
        step();
        chk("gl_sprk2", sprinkler_valve, 0);
        irrigation = 1'b0;
        step();
        chk("gl_busy3", busy, 0);
        irrigation = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("gl_sprk_arm", sprinkler_valve, 0);
        end
        step();
        chk("gl_sprk_on", sprinkler_valve, 1);
        chk("gl_runc", run_count, 1);

        // Mode toggles during RUN and REST never move the active valve.
        for (int i = 1; i <= 19; i++) begin
            mode = ~mode;
            step();
            chk("tg_sprk", sprinkler_valve, 1);
            chk("tg_drip", dripper_valve, 0);
        end
        mode = ~mode;
        step();
        chk("tg_end_sprk", sprinkler_valve, 0);
        chk("tg_end_runc", run_count, 2);
        chk("tg_end_busy", busy, 1);
        for (int i = 1; i <= 14; i++) begin
            if (i <= 9) mode = ~mode;
            else mode = 1'b1;
            step();
            chk("rs_sprk", sprinkler_valve, (i == 14) ? 1 : 0);
            chk("rs_drip", dripper_valve, 0);
            chk("rs_excl", dripper_valve & sprinkler_valve, 0);
        end

        // Asynchronous reset mid-RUN clears everything without a clock edge.
        repeat (2) step();
        chk("pre_rst_sprk", sprinkler_valve, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_sprk", sprinkler_valve, 0);
        chk("ar_busy", busy, 0);
        chk("ar_runc", run_count, 0);
        chk("ar_abtc", abort_count, 0);
        step();
        reset_n    = 1'b1;
        irrigation = 1'b1;
        mode       = 1'b0;

        // 256 back-to-back complete runs: run_count saturates at 255.
        for (int s = 1; s <= 8700; s++) begin
            step();
            if (s == 4)    chk("sat_start", dripper_valve, 1);
            if (s == 24)   chk("sat_first", run_count, 1);
            if (s == 8659) chk("sat_254", run_count, 254);
            if (s == 8660) chk("sat_255", run_count, 255);
            if (s == 8694) chk("sat_hold", run_count, 255);
        end
        chk("sat_abtc", abort_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
